gmsk_burst_sequencer: RTL and testbench
=======================================

Name: gmsk_burst_sequencer

Overview:
Sequences a single GMSK modulator instance through one transmit burst. Upstream logic loads the burst payload bits into an internal buffer. On a start pulse, the sequencer generates the modulator's sample strobe and presents one bit per symbol period on the modulator's next_symbol input, in this order: lead fill, payload, trail fill, guard. The block sits between the burst formatter (upstream) and the GMSK modulator, and reports busy/done to the TDMA timing controller.

Parameters:
CLOCK_DIV, 4, clock cycles per sample_strobe pulse (legal range 2..255)
MAX_BITS, 148, payload buffer depth in bits
LEAD_SYMBOLS, 4, fill symbols (value 0) sent before payload to prime the modulator pipeline
TRAIL_SYMBOLS, 4, fill symbols (value 0) sent after the last payload bit
GUARD_SYMBOLS, 8, symbols of continued strobing with next_symbol=0 before returning to idle

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  payload bit write request
load_bit  in  1  payload bit value
load_ready  out  1  buffer accepts a bit this cycle
start  in  1  single-cycle burst start request
abort  in  1  single-cycle abort request
mod_symbol_strobe  in  1  modulator symbol_strobe_o (level; high for one strobe interval per symbol)
sample_strobe  out  1  one-cycle strobe to the modulator
next_symbol  out  1  bit presented to the modulator
busy  out  1  high in any state other than IDLE
burst_done  out  1  one-cycle pulse on GUARD->IDLE transition
bit_count  out  $clog2(MAX_BITS+1)  number of payload bits currently loaded

Behaviour:
- Reset values: all outputs 0; load_ready=1 on the cycle after reset deasserts; buffer count 0; state IDLE. Reset mid-burst is an immediate return to IDLE, with the buffer cleared and strobing stopped.
- Load port: load_ready = (state==IDLE) && (bit_count<MAX_BITS). A bit is written at address bit_count when load_valid && load_ready; bit_count increments in the same cycle. Writes in any other case are dropped silently.
- start is accepted only in IDLE with bit_count>0. Otherwise it is ignored. If start and load_valid arrive in the same cycle, the load is accepted first, and the burst includes that bit.
- States: IDLE -> LEAD -> PAYLOAD -> TRAIL -> GUARD -> IDLE.
- Strobe divider: a mod-CLOCK_DIV counter, cleared on entry to LEAD. sample_strobe pulses when the counter equals CLOCK_DIV-1. No strobes in IDLE.
- Symbol advance event: rising edge of mod_symbol_strobe, detected against a registered copy. Exactly one advance occurs per symbol. next_symbol updates on the cycle after the edge and then holds until the next edge, so it is stable before the modulator latches.
- On entering LEAD, next_symbol=0 and the symbol counter is 0.
- Each advance increments the symbol counter, and the state-exit rules below are checked against it.
- LEAD: after LEAD_SYMBOLS advances, go to PAYLOAD and present buffer[0].
- PAYLOAD: each advance presents the next buffer bit. After bit_count-1 advances past buffer[0], the next advance goes to TRAIL with next_symbol=0.
- TRAIL: after TRAIL_SYMBOLS advances, go to GUARD.
- GUARD: after GUARD_SYMBOLS advances, go to IDLE. On that transition: pulse burst_done, clear bit_count, set next_symbol=0, stop strobes.
- abort in LEAD or PAYLOAD: go to TRAIL at the next cycle, next_symbol=0, symbol counter cleared.
- abort in TRAIL, GUARD or IDLE is ignored.
- If abort and a symbol advance occur in the same cycle, abort wins.
- Counters are sized so that max(LEAD, TRAIL, GUARD, MAX_BITS) does not wrap.
- The buffer is not writable while busy=1, so its contents are frozen for the whole burst.

Test Plan:
- Load 5 bits 1,0,1,1,0, pulse start, and drive mod_symbol_strobe from a behavioural modulator model -> next_symbol sequence per symbol is 0,0,0,0,1,0,1,1,0, then 0 x12. burst_done pulses exactly once, and busy spans 21 symbols.
- CLOCK_DIV=4, check sample_strobe spacing in every state -> exactly one pulse every 4 clocks. No pulse in IDLE. First pulse 4 cycles after start is accepted.
- Load MAX_BITS=148 bits, then attempt a 149th write -> load_ready=0, bit_count stays 148, and the burst transmits exactly 148 payload bits.
- start with bit_count=0 -> stays IDLE, busy=0, no strobes. start and load_valid in the same cycle -> a 1-bit burst is transmitted.
- abort during payload bit 3 of 10 -> next_symbol=0 from the next symbol. Then 4 trail + 8 guard symbols follow, and burst_done pulses.
- Assert reset mid-PAYLOAD for 1 cycle -> next cycle busy=0, sample_strobe=0, next_symbol=0, bit_count=0, load_ready=1. A new 2-bit load and start then runs correctly.

Source files
------------

// File: rtl/gmsk_burst_sequencer_if.sv
// Signal bundle between the burst formatter/TDMA controller/modulator side (master)
// and the burst sequencer (slave).
interface gmsk_burst_sequencer_if #(
  parameter int MAX_BITS = 148
);
  localparam int CNT_W = $clog2(MAX_BITS + 1);

  logic             load_valid;
  logic             load_bit;
  logic             load_ready;
  logic             start;
  logic             abort;
  logic             mod_symbol_strobe;
  logic             sample_strobe;
  logic             next_symbol;
  logic             busy;
  logic             burst_done;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output load_valid, load_bit, start, abort, mod_symbol_strobe,
    input  load_ready, sample_strobe, next_symbol, busy, burst_done, bit_count
  );

  modport slave (
    input  load_valid, load_bit, start, abort, mod_symbol_strobe,
    output load_ready, sample_strobe, next_symbol, busy, burst_done, bit_count
  );
endinterface

// File: rtl/gmsk_burst_sequencer.sv
// Drives one GMSK modulator through a transmit burst: payload buffer, sample-strobe
// divider, and symbol sequencing through lead fill, payload, trail fill and guard.
//
// state   | meaning
// IDLE    | buffer loadable, no strobes
// LEAD    | zero fill symbols priming the modulator pipeline
// PAYLOAD | buffered bits presented one per symbol
// TRAIL   | zero fill symbols after payload (also entered on abort)
// GUARD   | zero symbols with strobing continued, then burst_done
module gmsk_burst_sequencer #(
  parameter int CLOCK_DIV     = 4,
  parameter int MAX_BITS      = 148,
  parameter int LEAD_SYMBOLS  = 4,
  parameter int TRAIL_SYMBOLS = 4,
  parameter int GUARD_SYMBOLS = 8
) (
  input logic                   clock,
  input logic                   reset,
  gmsk_burst_sequencer_if.slave bus
);
  localparam int CNT_W   = $clog2(MAX_BITS + 1);
  localparam int ADDR_W  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int DIV_W   = $clog2(CLOCK_DIV);
  localparam int MAX_LT  = (LEAD_SYMBOLS > TRAIL_SYMBOLS) ? LEAD_SYMBOLS : TRAIL_SYMBOLS;
  localparam int MAX_GB  = (GUARD_SYMBOLS > MAX_BITS) ? GUARD_SYMBOLS : MAX_BITS;
  localparam int SYM_MAX = (MAX_LT > MAX_GB) ? MAX_LT : MAX_GB;
  localparam int SYM_W   = $clog2(SYM_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIV - 1);
  localparam logic [SYM_W-1:0] LEAD_LIM  = SYM_W'(LEAD_SYMBOLS);
  localparam logic [SYM_W-1:0] TRAIL_LIM = SYM_W'(TRAIL_SYMBOLS);
  localparam logic [SYM_W-1:0] GUARD_LIM = SYM_W'(GUARD_SYMBOLS);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_PAYLOAD,
    S_TRAIL,
    S_GUARD
  } state_t;

  state_t              state, state_next;
  logic [SYM_W-1:0]    sym_cnt, sym_cnt_next, sym_inc;
  logic [DIV_W-1:0]    div_cnt, div_cnt_next;
  logic [CNT_W-1:0]    bit_count, bit_count_next;
  logic [MAX_BITS-1:0] buffer;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                next_symbol, next_symbol_next;
  logic                burst_done, burst_done_next;
  logic                mod_strobe_q;
  logic                advance;
  logic                load_ready;
  logic                load_fire;

  assign load_ready = (state == S_IDLE) && (bit_count < FULL_CNT) && !reset;
  assign load_fire  = bus.load_valid && load_ready;
  assign advance    = bus.mod_symbol_strobe && !mod_strobe_q;
  assign sym_inc    = sym_cnt + SYM_W'(1);
  assign wr_addr    = ADDR_W'(bit_count);
  // In PAYLOAD the symbol counter doubles as the buffer read pointer.
  assign rd_addr    = ADDR_W'(sym_inc);

  always_comb begin
    state_next       = state;
    sym_cnt_next     = sym_cnt;
    next_symbol_next = next_symbol;
    burst_done_next  = 1'b0;
    bit_count_next   = bit_count;
    div_cnt_next     = '0;

    if (state != S_IDLE) begin
      div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
    if (load_fire) begin
      bit_count_next = bit_count + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        // A bit loaded in the same cycle as start counts toward a non-empty buffer.
        if (bus.start && ((bit_count != '0) || load_fire)) begin
          state_next       = S_LEAD;
          sym_cnt_next     = '0;
          next_symbol_next = 1'b0;
          div_cnt_next     = '0;
        end
      end
      S_LEAD: begin
        if (bus.abort) begin
          state_next       = S_TRAIL;
          sym_cnt_next     = '0;
          next_symbol_next = 1'b0;
        end else if (advance) begin
          if (sym_inc == LEAD_LIM) begin
            state_next       = S_PAYLOAD;
            sym_cnt_next     = '0;
            next_symbol_next = buffer[0];
          end else begin
            sym_cnt_next = sym_inc;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.abort) begin
          state_next       = S_TRAIL;
          sym_cnt_next     = '0;
          next_symbol_next = 1'b0;
        end else if (advance) begin
          if (sym_inc == SYM_W'(bit_count)) begin
            state_next       = S_TRAIL;
            sym_cnt_next     = '0;
            next_symbol_next = 1'b0;
          end else begin
            sym_cnt_next     = sym_inc;
            next_symbol_next = buffer[rd_addr];
          end
        end
      end
      S_TRAIL: begin
        if (advance) begin
          if (sym_inc == TRAIL_LIM) begin
            state_next   = S_GUARD;
            sym_cnt_next = '0;
          end else begin
            sym_cnt_next = sym_inc;
          end
        end
      end
      S_GUARD: begin
        if (advance) begin
          if (sym_inc == GUARD_LIM) begin
            state_next       = S_IDLE;
            sym_cnt_next     = '0;
            next_symbol_next = 1'b0;
            burst_done_next  = 1'b1;
            bit_count_next   = '0;
          end else begin
            sym_cnt_next = sym_inc;
          end
        end
      end
      default: begin
        state_next       = S_IDLE;
        sym_cnt_next     = '0;
        next_symbol_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      sym_cnt      <= '0;
      div_cnt      <= '0;
      bit_count    <= '0;
      buffer       <= '0;
      next_symbol  <= 1'b0;
      burst_done   <= 1'b0;
      mod_strobe_q <= 1'b0;
    end else begin
      state        <= state_next;
      sym_cnt      <= sym_cnt_next;
      div_cnt      <= div_cnt_next;
      bit_count    <= bit_count_next;
      next_symbol  <= next_symbol_next;
      burst_done   <= burst_done_next;
      mod_strobe_q <= bus.mod_symbol_strobe;
      if (load_fire) begin
        buffer[wr_addr] <= bus.load_bit;
      end
    end
  end

  assign bus.load_ready    = load_ready;
  assign bus.sample_strobe = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign bus.next_symbol   = next_symbol;
  assign bus.busy          = (state != S_IDLE);
  assign bus.burst_done    = burst_done;
  assign bus.bit_count     = bit_count;
endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench for gmsk_burst_sequencer with a behavioural modulator that raises
// symbol_strobe for one strobe interval every SPS sample strobes.
module tb_gmsk_burst_sequencer;
  localparam int CLOCK_DIV = 4;
  localparam int MAX_BITS  = 148;
  localparam int LEAD      = 4;
  localparam int TRAIL     = 4;
  localparam int GUARD     = 8;
  localparam int SPS       = 4;
  localparam int SYM_CLKS  = SPS * CLOCK_DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  int errors = 0;
  int checks = 0;

  gmsk_burst_sequencer_if #(.MAX_BITS(MAX_BITS)) bus ();

  gmsk_burst_sequencer #(
    .CLOCK_DIV    (CLOCK_DIV),
    .MAX_BITS     (MAX_BITS),
    .LEAD_SYMBOLS (LEAD),
    .TRAIL_SYMBOLS(TRAIL),
    .GUARD_SYMBOLS(GUARD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor and modulator model, all cumulative; the stimulus block takes snapshots.
  int sps_cnt          = 0;
  int prev_strobe      = -1;
  int first_strobe_cyc = -1;
  int strobe_n         = 0;
  int idle_strobes     = 0;
  int gap_bad          = 0;
  int done_n           = 0;
  int busy_cycles      = 0;
  int sym_n            = 0;
  bit sym_log [0:511];

  always @(negedge clock) begin
    if (reset) begin
      sps_cnt               = 0;
      prev_strobe           = -1;
      bus.mod_symbol_strobe = 1'b0;
    end else begin
      if (bus.busy) busy_cycles++;
      if (bus.burst_done) done_n++;
      if (bus.sample_strobe) begin
        if (!bus.busy) idle_strobes++;
        else begin
          strobe_n++;
          if (prev_strobe < 0) first_strobe_cyc = cyc;
          else if (cyc - prev_strobe != CLOCK_DIV) gap_bad++;
          prev_strobe = cyc;
        end
      end
      if (!bus.busy) begin
        prev_strobe           = -1;
        sps_cnt               = 0;
        bus.mod_symbol_strobe = 1'b0;
      end else if (bus.sample_strobe) begin
        if (sps_cnt == SPS - 1) begin
          // Log the symbol the modulator latches as this symbol period closes.
          if (sym_n < 512) sym_log[sym_n] = bus.next_symbol;
          sym_n++;
          sps_cnt               = 0;
          bus.mod_symbol_strobe = 1'b1;
        end else begin
          sps_cnt++;
          bus.mod_symbol_strobe = 1'b0;
        end
      end
    end
  end

  int b_sym, b_done, b_busy, b_strobe, b_idle;
  int start_cyc;
  bit payload[$];
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_sym    = sym_n;
    b_done   = done_n;
    b_busy   = busy_cycles;
    b_strobe = strobe_n;
    b_idle   = idle_strobes;
  endtask

  task automatic load_payload();
    for (int i = 0; i < payload.size(); i++) begin
      @(negedge clock);
      bus.load_valid = 1'b1;
      bus.load_bit   = payload[i];
    end
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_bit   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_n == b_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_n > b_done), 1);
    repeat (6) @(negedge clock);
  endtask

  task automatic wait_syms(input string tag, input int target, input int budget);
    int n = 0;
    while (sym_n - b_sym < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_sym_reach"}, 32'(sym_n - b_sym >= target), 1);
  endtask

  task automatic build_normal_exp();
    exp_q.delete();
    for (int i = 0; i < LEAD; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < payload.size(); i++) exp_q.push_back(payload[i]);
    for (int i = 0; i < TRAIL + GUARD; i++) exp_q.push_back(1'b0);
  endtask

  task automatic check_syms(input string tag);
    int mism  = 0;
    int first = -1;
    int got   = sym_n - b_sym;
    check({tag, "_sym_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      if (b_sym + i < 512 && sym_log[b_sym + i] !== exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) $display("note: %s first differing symbol index %0d", tag, first);
    check({tag, "_sym_values"}, mism, 0);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_bit   = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    reset          = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy",        32'(bus.busy), 0);
    check("rst_strobe",      32'(bus.sample_strobe), 0);
    check("rst_next_symbol", 32'(bus.next_symbol), 0);
    check("rst_done",        32'(bus.burst_done), 0);
    check("rst_bit_count",   32'(bus.bit_count), 0);
    check("rst_load_ready",  32'(bus.load_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_load_ready", 32'(bus.load_ready), 1);

    // start with an empty buffer is ignored
    snap();
    pulse_start();
    repeat (12) @(negedge clock);
    check("empty_start_busy",    32'(bus.busy), 0);
    check("empty_start_strobes", strobe_n + idle_strobes - b_strobe - b_idle, 0);

    // Basic 5-bit burst
    payload = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    load_payload();
    check("basic_bit_count", 32'(bus.bit_count), 5);
    snap();
    pulse_start();
    check("basic_busy", 32'(bus.busy), 1);
    wait_done("basic", 2000);
    build_normal_exp();
    check_syms("basic");
    check("basic_done_once",   done_n - b_done, 1);
    check("basic_busy_cycles", busy_cycles - b_busy, 21 * SYM_CLKS);
    check("basic_strobe_n",    strobe_n - b_strobe, 21 * SPS);
    check("basic_first_strobe", first_strobe_cyc - start_cyc, CLOCK_DIV);
    check("basic_gap_bad",     gap_bad, 0);
    check("basic_idle_strobes", idle_strobes, 0);
    check("basic_end_busy",    32'(bus.busy), 0);
    check("basic_end_bit_count", 32'(bus.bit_count), 0);
    check("basic_end_load_ready", 32'(bus.load_ready), 1);

    // Full buffer and a dropped 149th write
    payload.delete();
    for (int i = 0; i < MAX_BITS; i++) payload.push_back(((i * 5) % 7) < 3);
    load_payload();
    check("full_bit_count",  32'(bus.bit_count), MAX_BITS);
    check("full_load_ready", 32'(bus.load_ready), 0);
    bus.load_valid = 1'b1;
    bus.load_bit   = 1'b1;
    @(negedge clock);
    bus.load_valid = 1'b0;
    check("overflow_bit_count", 32'(bus.bit_count), MAX_BITS);
    snap();
    pulse_start();
    wait_done("full", 4000);
    build_normal_exp();
    check_syms("full");
    check("full_busy_cycles", busy_cycles - b_busy, (LEAD + MAX_BITS + TRAIL + GUARD) * SYM_CLKS);
    check("full_gap_bad", gap_bad, 0);

    // start and load_valid in the same cycle
    snap();
    @(negedge clock);
    bus.load_valid = 1'b1;
    bus.load_bit   = 1'b1;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_bit   = 1'b0;
    bus.start      = 1'b0;
    check("same_cycle_busy",      32'(bus.busy), 1);
    check("same_cycle_bit_count", 32'(bus.bit_count), 1);
    wait_done("same_cycle", 2000);
    payload = '{1'b1};
    build_normal_exp();
    check_syms("same_cycle");

    // Abort while payload bit 3 (of 10) is on next_symbol
    payload = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_payload();
    snap();
    pulse_start();
    wait_syms("abort", LEAD + 3, 2000);
    repeat (3) @(negedge clock);
    check("abort_pre_symbol", 32'(bus.next_symbol), 1);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_next_symbol", 32'(bus.next_symbol), 0);
    check("abort_busy",        32'(bus.busy), 1);
    wait_done("abort", 2000);
    exp_q.delete();
    for (int i = 0; i < LEAD; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back(payload[i]);
    for (int i = 0; i < 1 + TRAIL - 1 + GUARD; i++) exp_q.push_back(1'b0);
    check_syms("abort");
    check("abort_done_once", done_n - b_done, 1);
    check("abort_gap_bad",   gap_bad, 0);

    // Reset mid-PAYLOAD, then a fresh 2-bit burst
    payload = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    load_payload();
    snap();
    pulse_start();
    wait_syms("midrst", LEAD + 1, 2000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy",        32'(bus.busy), 0);
    check("midrst_strobe",      32'(bus.sample_strobe), 0);
    check("midrst_next_symbol", 32'(bus.next_symbol), 0);
    check("midrst_bit_count",   32'(bus.bit_count), 0);
    check("midrst_load_ready",  32'(bus.load_ready), 1);
    payload = '{1'b1, 1'b1};
    load_payload();
    check("midrst_reload_count", 32'(bus.bit_count), 2);
    snap();
    pulse_start();
    wait_done("midrst", 2000);
    build_normal_exp();
    check_syms("midrst");
    check("midrst_done_once", done_n - b_done, 1);
    check("final_idle_strobes", idle_strobes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
